// File: rtl/iobus_target_router_pkg.sv
// rtl/iobus_target_router_pkg.sv - shared state encodings, error byte and err_flags bit indices
package iobus_target_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  localparam logic [7:0] ERR_BYTE = 8'hDE;

  localparam int FLAG_TIMEOUT     = 0;
  localparam int FLAG_UNMAPPED    = 1;
  localparam int FLAG_STRAY       = 2;
  localparam int FLAG_STROBE_BUSY = 3;

endpackage

// File: rtl/iobus_timeout_timer.sv
// rtl/iobus_timeout_timer.sv - busy-cycle counter flagging the last cycle before forced completion
module iobus_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Count holds the number of BUSY cycles already completed.
  assign expired = (count_q == LAST);

endmodule

// File: rtl/iobus_target_router.sv
// rtl/iobus_target_router.sv - registered IO bus target router; IOBUS_ROUTER_ERR_STATUS_EN adds err_clr/err_flags
module iobus_target_router
  import iobus_target_router_pkg::*;
#(
  parameter int CORE_COUNT     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SEL_LSB        = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           io_addr_strobe,
  input  logic                           io_read_strobe,
  input  logic [ADDR_WIDTH-1:0]          io_address,
  output logic [DATA_WIDTH-1:0]          io_read_data,
  output logic                           io_ready,
  output logic [CORE_COUNT-1:0]          tgt_addr_strobe,
  input  logic [DATA_WIDTH*CORE_COUNT-1:0] tgt_read_data,
  input  logic [CORE_COUNT-1:0]          tgt_ready
`ifdef IOBUS_ROUTER_ERR_STATUS_EN
  ,
  input  logic                           err_clr,
  output logic [3:0]                     err_flags
`endif
);

  localparam int SEL_BITS  = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
  localparam int ERR_BYTES = (DATA_WIDTH + 7) / 8;
  localparam logic [ERR_BYTES*8-1:0] ERR_FULL = {ERR_BYTES{ERR_BYTE}};
  localparam logic [DATA_WIDTH-1:0]  ERR_WORD = ERR_FULL[DATA_WIDTH-1:0];
  localparam logic [SEL_BITS:0]      CORE_LIMIT = (SEL_BITS + 1)'(CORE_COUNT);

  state_e                state_q, state_d;
  logic [SEL_BITS-1:0]   sel_q, sel_d, idx;
  logic                  is_read_q, is_read_d;
  logic                  io_ready_q, io_ready_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, sel_data;
  logic                  mapped, sel_ready;
  logic                  tmr_clear, tmr_en, tmr_expired;
  logic                  unused_addr_bits;

  assign idx              = io_address[SEL_LSB +: SEL_BITS];
  assign mapped           = ({1'b0, idx} < CORE_LIMIT);
  assign unused_addr_bits = ^io_address;

  always_comb begin
    tgt_addr_strobe = '0;
    sel_data        = '0;
    sel_ready       = 1'b0;
    for (int i = 0; i < CORE_COUNT; i++) begin
      if (io_addr_strobe && (state_q == ST_IDLE) && mapped && (idx == SEL_BITS'(i))) begin
        tgt_addr_strobe[i] = 1'b1;
      end
      if (sel_q == SEL_BITS'(i)) begin
        sel_data  = tgt_read_data[DATA_WIDTH*i +: DATA_WIDTH];
        sel_ready = tgt_ready[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    is_read_d  = is_read_q;
    io_ready_d = 1'b0;
    rdata_d    = rdata_q;
    tmr_clear  = 1'b0;
    tmr_en     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (io_addr_strobe) begin
          if (mapped) begin
            sel_d     = idx;
            is_read_d = io_read_strobe;
            tmr_clear = 1'b1;
            state_d   = ST_BUSY;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_BUSY: begin
        tmr_en = 1'b1;
        // A response arriving on the final cycle still beats the timeout.
        if (sel_ready) begin
          io_ready_d = 1'b1;
          rdata_d    = is_read_q ? sel_data : '0;
          state_d    = ST_IDLE;
        end else if (tmr_expired) begin
          io_ready_d = 1'b1;
          rdata_d    = ERR_WORD;
          state_d    = ST_IDLE;
        end
      end
      ST_ERR: begin
        io_ready_d = 1'b1;
        rdata_d    = ERR_WORD;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      is_read_q  <= 1'b0;
      io_ready_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      is_read_q  <= is_read_d;
      io_ready_q <= io_ready_d;
      rdata_q    <= rdata_d;
    end
  end

  assign io_ready     = io_ready_q;
  assign io_read_data = rdata_q;

  iobus_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expired(tmr_expired)
  );

`ifdef IOBUS_ROUTER_ERR_STATUS_EN
  logic [3:0]            flags_q, flags_d, flag_evt;
  logic [CORE_COUNT-1:0] sel_mask;

  always_comb begin
    sel_mask = '0;
    for (int i = 0; i < CORE_COUNT; i++) begin
      if (sel_q == SEL_BITS'(i)) sel_mask[i] = 1'b1;
    end
    flag_evt                   = '0;
    flag_evt[FLAG_TIMEOUT]     = (state_q == ST_BUSY) && tmr_expired && !sel_ready;
    flag_evt[FLAG_UNMAPPED]    = (state_q == ST_IDLE) && io_addr_strobe && !mapped;
    flag_evt[FLAG_STRAY]       = ((state_q != ST_BUSY) && (|tgt_ready)) ||
                                 ((state_q == ST_BUSY) && (|(tgt_ready & ~sel_mask)));
    flag_evt[FLAG_STROBE_BUSY] = (state_q != ST_IDLE) && io_addr_strobe;
    // New events override a simultaneous clear.
    flags_d = (err_clr ? 4'b0000 : flags_q) | flag_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign err_flags = flags_q;
`endif

endmodule
